// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared types and default sizing for the N-port reorder buffer
//
// Purpose : default configuration constants and entry/tag types for rob_nport
//           and its commit selector. The ROB_* values are the defaults of the
//           module parameters. rob_entry_t and rob_tag_t describe the default
//           configuration for blocks that exchange ROB entries or tags.
// Ports   : none (package)

package rob_pkg;

   localparam int ROB_DEPTH    = 16;
   localparam int ROB_WB_PORTS = 2;
   localparam int ROB_COMMIT_W = 2;
   localparam int ROB_DATA_W   = 32;
   localparam int ROB_RD_W     = 5;
   localparam int ROB_TAG_W    = $clog2(ROB_DEPTH);

   typedef logic [ROB_TAG_W-1:0] rob_tag_t;

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic [ROB_RD_W-1:0]   rd;
      logic [ROB_DATA_W-1:0] data;
   } rob_entry_t;

endpackage

// File: rtl/rob_commit_sel.sv
// rtl/rob_commit_sel.sv - prefix scan of retire-ready entries starting at head
//
// Purpose : combinational. Walks COMMIT_W entries from head (wrapping mod
//           DEPTH) and stops at the first entry that is not ready. The result
//           is a prefix mask, so a younger entry never retires ahead of an
//           older one.
// Ports   : head         in  TAG_W     oldest entry index
//           flush        in  1         suppresses all retirement
//           ready        in  DEPTH     per-entry valid & done
//           commit_valid out COMMIT_W  prefix mask of retiring slots
//           retire_n     out RN_W      popcount of commit_valid

module rob_commit_sel
   import rob_pkg::*;
#(
   parameter int DEPTH    = ROB_DEPTH,
   parameter int COMMIT_W = ROB_COMMIT_W,
   localparam int TAG_W   = $clog2(DEPTH),
   localparam int RN_W    = $clog2(COMMIT_W + 1)
) (
   input  logic [TAG_W-1:0]    head,
   input  logic                flush,
   input  logic [DEPTH-1:0]    ready,
   output logic [COMMIT_W-1:0] commit_valid,
   output logic [RN_W-1:0]     retire_n
);

   logic             run;
   logic [TAG_W-1:0] idx;

   always_comb begin
      run          = ~flush;
      idx          = '0;
      commit_valid = '0;
      retire_n     = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         idx             = head + TAG_W'(k);
         // once one entry is not ready, every younger slot stays clear
         run             = run & ready[idx];
         commit_valid[k] = run;
         if (run)
            retire_n = retire_n + RN_W'(1);
      end
   end

endmodule

// File: rtl/rob_nport.sv
// rtl/rob_nport.sv - parametrised reorder buffer, N writeback ports, up to COMMIT_W retires/cycle
//
// Purpose : in-order allocate, out-of-order writeback capture, in-order retire.
//           full/empty come from count, not pointer equality, so a completely
//           full buffer is unambiguous.
// Config  : `define ROB_WB_BYPASS_EN lets a writeback hit retire in the same
//           cycle, with data taken from the writeback channel. Without it only
//           registered done/data feed retirement (earliest retire is one cycle
//           after writeback).
// Ports   : clk, rst (async, active-high), flush
//           alloc_valid/alloc_rd in, alloc_ready/alloc_tag out
//           wb_valid[WB_PORTS], wb_tag[WB_PORTS*TAG_W], wb_data[WB_PORTS*DATA_W] in
//           commit_valid/rd/data/tag out (slot 0 = oldest), count, empty, full out

module rob_nport
   import rob_pkg::*;
#(
   parameter int DEPTH    = ROB_DEPTH,
   parameter int WB_PORTS = ROB_WB_PORTS,
   parameter int COMMIT_W = ROB_COMMIT_W,
   parameter int DATA_W   = ROB_DATA_W,
   parameter int RD_W     = ROB_RD_W,
   localparam int TAG_W   = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         alloc_valid,
   input  logic [RD_W-1:0]              alloc_rd,
   output logic                         alloc_ready,
   output logic [TAG_W-1:0]             alloc_tag,
   input  logic [WB_PORTS-1:0]          wb_valid,
   input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
   input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
   output logic [COMMIT_W-1:0]          commit_valid,
   output logic [COMMIT_W*RD_W-1:0]     commit_rd,
   output logic [COMMIT_W*DATA_W-1:0]   commit_data,
   output logic [COMMIT_W*TAG_W-1:0]    commit_tag,
   output logic [TAG_W:0]               count,
   output logic                         empty,
   output logic                         full
);

   localparam int CNT_W = TAG_W + 1;
   localparam int RN_W  = $clog2(COMMIT_W + 1);

   typedef struct packed {
      logic              valid;
      logic              done;
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            ent [DEPTH];
   logic [TAG_W-1:0]  head;
   logic [TAG_W-1:0]  tail;

   logic [DEPTH-1:0]  wb_hit;
   logic [DATA_W-1:0] wb_dat  [DEPTH];
   logic [TAG_W-1:0]  wb_t;
   logic [DEPTH-1:0]  ready;
   logic [TAG_W-1:0]  slot_idx [COMMIT_W];
   logic [RN_W-1:0]   retire_n;
   logic              alloc_fire;

   assign full        = (count == CNT_W'(DEPTH));
   assign empty       = (count == '0);
   assign alloc_ready = ~full;
   assign alloc_tag   = tail;
   assign alloc_fire  = alloc_valid & alloc_ready;

   // Resolve writeback channels per entry. Scanning from the highest channel
   // down lets the lowest-numbered channel overwrite, so it wins on a tag clash.
   always_comb begin
      wb_hit = '0;
      wb_t   = '0;
      for (int e = 0; e < DEPTH; e++)
         wb_dat[e] = '0;
      for (int i = WB_PORTS - 1; i >= 0; i--) begin
         if (wb_valid[i]) begin
            wb_t         = wb_tag[i*TAG_W +: TAG_W];
            wb_hit[wb_t] = 1'b1;
            wb_dat[wb_t] = wb_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
`ifdef ROB_WB_BYPASS_EN
         ready[e] = ent[e].valid & (ent[e].done | wb_hit[e]);
`else
         ready[e] = ent[e].valid & ent[e].done;
`endif
      end
   end

   rob_commit_sel #(
      .DEPTH    (DEPTH),
      .COMMIT_W (COMMIT_W)
   ) u_commit_sel (
      .head         (head),
      .flush        (flush),
      .ready        (ready),
      .commit_valid (commit_valid),
      .retire_n     (retire_n)
   );

   // Commit payload is zeroed on idle slots so downstream never sees stale data.
   always_comb begin
      commit_rd   = '0;
      commit_data = '0;
      commit_tag  = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         slot_idx[k] = head + TAG_W'(k);
         if (commit_valid[k]) begin
            commit_rd[k*RD_W +: RD_W]    = ent[slot_idx[k]].rd;
            commit_tag[k*TAG_W +: TAG_W] = slot_idx[k];
`ifdef ROB_WB_BYPASS_EN
            commit_data[k*DATA_W +: DATA_W] = wb_hit[slot_idx[k]] ? wb_dat[slot_idx[k]]
                                                                  : ent[slot_idx[k]].data;
`else
            commit_data[k*DATA_W +: DATA_W] = ent[slot_idx[k]].data;
`endif
         end
      end
   end

   // Update order inside the edge: writeback, then allocate, then retire-clear.
   // Allocate only targets a free slot, so it never collides with a retiring one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int e = 0; e < DEPTH; e++)
            ent[e] <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int e = 0; e < DEPTH; e++) begin
            ent[e].valid <= 1'b0;
            ent[e].done  <= 1'b0;
         end
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            if (wb_hit[e] && ent[e].valid) begin
               ent[e].done <= 1'b1;
               ent[e].data <= wb_dat[e];
            end
         end
         if (alloc_fire) begin
            ent[tail].valid <= 1'b1;
            ent[tail].done  <= 1'b0;
            ent[tail].rd    <= alloc_rd;
         end
         for (int k = 0; k < COMMIT_W; k++) begin
            if (commit_valid[k]) begin
               ent[slot_idx[k]].valid <= 1'b0;
               ent[slot_idx[k]].done  <= 1'b0;
            end
         end
         head  <= head + TAG_W'(retire_n);
         tail  <= tail + TAG_W'(alloc_fire);
         count <= count + CNT_W'(alloc_fire) - CNT_W'(retire_n);
      end
   end

endmodule

// File: tb/tb_rob_nport.sv
// tb/tb_rob_nport.sv - scoreboard bench for rob_nport (DEPTH=4, WB_PORTS=2, COMMIT_W=2)

module tb_rob_nport;

   localparam bit BYP =
`ifdef ROB_WB_BYPASS_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        alloc_valid;
   logic [4:0]  alloc_rd;
   logic        alloc_ready;
   logic [1:0]  alloc_tag;
   logic [1:0]  wb_valid;
   logic [3:0]  wb_tag;
   logic [63:0] wb_data;
   logic [1:0]  commit_valid;
   logic [9:0]  commit_rd;
   logic [63:0] commit_data;
   logic [3:0]  commit_tag;
   logic [2:0]  count;
   logic        empty;
   logic        full;

   rob_nport #(.DEPTH(4), .WB_PORTS(2), .COMMIT_W(2), .DATA_W(32), .RD_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
      .commit_valid(commit_valid), .commit_rd(commit_rd),
      .commit_data(commit_data), .commit_tag(commit_tag),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   // reference model: program-order list of in-flight instructions
   typedef struct { int tag; int rd; bit done; logic [31:0] data; } ment_t;
   typedef struct { int tag; int rd; logic [31:0] data; } exp_t;
   ment_t mq[$];
   exp_t  sbq[$];
   int    m_tail;
   int    total = 0;
   int    bad   = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_wb(input bit v0, input int t0, input logic [31:0] d0,
                           input bit v1, input int t1, input logic [31:0] d1);
      bit vv[2];
      int tt[2];
      logic [31:0] dd[2];
      bit claimed[4];
      vv[0] = v0; tt[0] = t0; dd[0] = d0;
      vv[1] = v1; tt[1] = t1; dd[1] = d1;
      for (int i = 0; i < 4; i++) claimed[i] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (vv[i] && !claimed[tt[i]]) begin
            claimed[tt[i]] = 1'b1;
            foreach (mq[j]) begin
               if (mq[j].tag == tt[i]) begin
                  mq[j].done = 1'b1;
                  mq[j].data = dd[i];
               end
            end
         end
      end
   endtask

   task automatic cycle(input bit av, input int ard,
                        input bit v0, input int t0, input logic [31:0] d0,
                        input bit v1, input int t1, input logic [31:0] d1,
                        input bit fl);
      int n;
      bit can_alloc;
      exp_t e;
      @(negedge clk);
      alloc_valid = av;
      alloc_rd    = 5'(ard);
      wb_valid    = {v1, v0};
      wb_tag      = {2'(t1), 2'(t0)};
      wb_data     = {d1, d0};
      flush       = fl;
      #1;
      chk("count", count, mq.size());
      chk("alloc_ready", alloc_ready, mq.size() < 4);
      chk("alloc_tag", alloc_tag, m_tail);
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == 4);
      if (fl) begin
         mq.delete();
         m_tail = 0;
         return;
      end
      can_alloc = (mq.size() < 4);
      if (BYP) model_wb(v0, t0, d0, v1, t1, d1);
      n = 0;
      while (n < 2 && n < mq.size() && mq[n].done) n++;
      for (int k = 0; k < n; k++) begin
         e.tag = mq[k].tag; e.rd = mq[k].rd; e.data = mq[k].data;
         sbq.push_back(e);
      end
      if (!BYP) model_wb(v0, t0, d0, v1, t1, d1);
      for (int k = 0; k < n; k++) void'(mq.pop_front());
      if (av && can_alloc) begin
         mq.push_back('{tag: m_tail, rd: ard, done: 1'b0, data: 32'h0});
         m_tail = (m_tail + 1) % 4;
      end
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic alloc(input int rd);
      cycle(1, rd, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wb1(input int t, input logic [31:0] d);
      cycle(0, 0, 1, t, d, 0, 0, 0, 0);
   endtask

   // monitor: pops the scoreboard whenever the DUT retires
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         total++;
         if (commit_valid == 2'b10) begin
            bad++;
            $display("FAIL commit_prefix: got %b", commit_valid);
         end
         for (int k = 0; k < 2; k++) begin
            if (commit_valid[k]) begin
               total++;
               if (sbq.size() == 0) begin
                  bad++;
                  $display("FAIL commit_extra: slot %0d tag %0d, nothing expected", k,
                           commit_tag[k*2 +: 2]);
               end else begin
                  e = sbq.pop_front();
                  if (commit_tag[k*2 +: 2] != 2'(e.tag) || commit_rd[k*5 +: 5] != 5'(e.rd)
                      || commit_data[k*32 +: 32] != e.data) begin
                     bad++;
                     $display("FAIL commit_slot%0d: got tag=%0d rd=%0d data=%h expected tag=%0d rd=%0d data=%h",
                              k, commit_tag[k*2 +: 2], commit_rd[k*5 +: 5], commit_data[k*32 +: 32],
                              e.tag, e.rd, e.data);
                  end
               end
            end
         end
      end
   end

   initial begin
      int t0, t1;
      rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_rd = '0;
      wb_valid = '0; wb_tag = '0; wb_data = '0;
      m_tail = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_count", count, 0);
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_alloc_tag", alloc_tag, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_commit_rd", commit_rd, 0);
      chk("rst_commit_data", commit_data, 0);
      chk("rst_commit_tag", commit_tag, 0);
      rst = 1'b0;

      // fill to full, fifth allocate must be ignored
      for (int i = 1; i <= 5; i++) alloc(i);
      idle();
      // out-of-order writeback, in-order pair retire
      wb1(1, 32'hB);
      wb1(0, 32'hA);
      idle();
      // younger done, older pending: nothing may retire
      wb1(3, 32'h33);
      idle();
      idle();
      wb1(2, 32'h22);
      idle();
      idle();

      // both channels hit the same tag: channel 0 wins
      alloc(9);
      cycle(0, 0, 1, mq[0].tag, 32'h11, 1, mq[0].tag, 32'h22, 0);
      idle();
      idle();

      // flush with a done head plus simultaneous alloc and writeback
      alloc(3); alloc(4); alloc(5);
      wb1(mq[0].tag, 32'h55);
      cycle(1, 7, 1, mq[1].tag, 32'h66, 0, 0, 0, 1);
      idle();

      // wrap: bring head/tail to 3, then allocate across the wrap
      alloc(1); alloc(2); alloc(3);
      cycle(0, 0, 1, 0, 32'h100, 1, 1, 32'h101, 0);
      wb1(2, 32'h102);
      idle();
      idle();
      alloc(6); alloc(7);
      cycle(0, 0, 1, 3, 32'h103, 1, 0, 32'h104, 0);
      idle();
      idle();

      // asynchronous reset in the middle of a cycle
      alloc(8); alloc(9);
      @(negedge clk);
      alloc_valid = 1'b0; wb_valid = '0; flush = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_empty", empty, 1);
      chk("async_rst_tag", alloc_tag, 0);
      chk("async_rst_ready", alloc_ready, 1);
      #1 rst = 1'b0;
      mq.delete();
      m_tail = 0;

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         t0 = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[$urandom_range(0, mq.size() - 1)].tag
                                                            : int'($urandom_range(0, 3));
         t1 = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[$urandom_range(0, mq.size() - 1)].tag
                                                            : int'($urandom_range(0, 3));
         cycle($urandom_range(0, 99) < 60, int'($urandom_range(0, 31)),
               $urandom_range(0, 1) == 1, t0, $urandom,
               $urandom_range(0, 1) == 1, t1, $urandom,
               $urandom_range(0, 99) < 3);
      end
      idle();
      idle();
      chk("scoreboard_drain", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
